// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline register with a 2-entry skid buffer, synchronous flush
// and a saturating stall-cycle counter. in_ready is decoded from state only.
module pipe_stage_reg #(
  parameter int unsigned           WIDTH       = 32,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0,
  parameter int unsigned           CNT_WIDTH   = 16
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 clr_stats,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [1:0]           occupancy,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       main_q,  main_d;
  logic [WIDTH-1:0]       skid_q,  skid_d;
  logic [CNT_WIDTH-1:0]   cnt_q,   cnt_d;

  logic in_fire, out_fire, stall;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != FULL);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign stall     = out_valid & ~out_ready;

  assign out_data  = main_q;
  assign occupancy = 2'(state_q);
  assign stall_cnt = cnt_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Bubble insertion: drop held entries and this cycle's input transfer.
      state_d = EMPTY;
      main_d  = RESET_VALUE;
      skid_d  = RESET_VALUE;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_stats)
      cnt_d = '0;
    else if (stall && (cnt_q != CNT_MAX))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= RESET_VALUE;
      skid_q  <= RESET_VALUE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

  // Downstream may rely on a held payload while it back-pressures.
  a_hold_stable: assert property (@(posedge clock) disable iff (rst)
    (out_valid && !out_ready && !flush) |=> $stable(out_data));

  a_occ_legal: assert property (@(posedge clock) disable iff (rst)
    occupancy != 2'd3);

endmodule
